// File: rtl/lsu_ctrl.sv
// Load/store unit controller between the MEM stage and a 32-bit data memory.
// Takes one request at a time, checks it for faults, drives one access cycle
// to the memory, then holds a registered response until it is consumed.
// Optional feature macro: LSU_MISALIGN_TRAP_EN. When it is defined, misaligned
// half/word requests return err=01. When it is undefined, the low address bits
// are forced to zero and the access proceeds.
module lsu_ctrl #(
    parameter int DMEM_WORDS = 256,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [2:0]       req_funct3,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_rdata,
    output logic [1:0]       resp_err,
    output logic [31:0]      dmem_addr,
    output logic [31:0]      dmem_wr_data,
    output logic             dmem_mem_wr,
    output logic             dmem_mem_rd,
    output logic [2:0]       dmem_mask,
    input  logic [31:0]      dmem_rd_data,
    output logic [CNT_W-1:0] load_cnt,
    output logic [CNT_W-1:0] store_cnt
);

    localparam logic [31:0] DMEM_WORDS_L = 32'(DMEM_WORDS);
    localparam logic [1:0]  ERR_OK       = 2'b00;
    localparam logic [1:0]  ERR_MISALIGN = 2'b01;
    localparam logic [1:0]  ERR_RANGE    = 2'b10;
    localparam logic [1:0]  ERR_FUNCT3   = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t state;
    state_t state_next;

    logic        we_q;
    logic        illegal;
    logic        out_of_range;
    logic [1:0]  req_err;
    logic [31:0] eff_addr;
    logic [31:0] lane_data;

    // Classify the incoming request, in priority order illegal > misaligned > range.
`ifdef LSU_MISALIGN_TRAP_EN
    logic misaligned;

    always_comb begin
        illegal      = req_we ? (req_funct3 > 3'b010)
                              : ((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11));
        misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        out_of_range = {2'b00, req_addr[31:2]} >= DMEM_WORDS_L;
        eff_addr     = req_addr;
        if (illegal) begin
            req_err = ERR_FUNCT3;
        end else if (misaligned) begin
            req_err = ERR_MISALIGN;
        end else if (out_of_range) begin
            req_err = ERR_RANGE;
        end else begin
            req_err = ERR_OK;
        end
    end
`else
    always_comb begin
        illegal      = req_we ? (req_funct3 > 3'b010)
                              : ((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11));
        out_of_range = {2'b00, req_addr[31:2]} >= DMEM_WORDS_L;
        eff_addr     = req_addr;
        if (req_funct3[1:0] == 2'b01) begin
            eff_addr[0] = 1'b0;
        end else if (req_funct3[1:0] == 2'b10) begin
            eff_addr[1:0] = 2'b00;
        end
        if (illegal) begin
            req_err = ERR_FUNCT3;
        end else if (out_of_range) begin
            req_err = ERR_RANGE;
        end else begin
            req_err = ERR_OK;
        end
    end
`endif

    // Replicate store data so the memory finds it on whichever lane it writes.
    always_comb begin
        case (req_funct3[1:0])
            2'b00:   lane_data = {4{req_wdata[7:0]}};
            2'b01:   lane_data = {2{req_wdata[15:0]}};
            default: lane_data = req_wdata;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and handshake/strobe outputs.
    always_comb begin
        state_next  = state;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        dmem_mem_rd = 1'b0;
        dmem_mem_wr = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = (req_err != ERR_OK) ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                dmem_mem_rd = !we_q;
                dmem_mem_wr = we_q;
                state_next  = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Latch the request on acceptance and capture load data at the end of ACCESS.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q         <= 1'b0;
            dmem_addr    <= '0;
            dmem_wr_data <= '0;
            dmem_mask    <= '0;
            resp_err     <= ERR_OK;
            resp_rdata   <= '0;
        end else if ((state == IDLE) && req_valid) begin
            we_q         <= req_we;
            dmem_addr    <= eff_addr;
            dmem_wr_data <= lane_data;
            dmem_mask    <= req_funct3;
            resp_err     <= req_err;
            resp_rdata   <= '0;
        end else if (state == ACCESS) begin
            resp_rdata   <= we_q ? 32'h0 : dmem_rd_data;
        end
    end

    // Count completed fault-free loads and stores when the response is consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_cnt  <= '0;
            store_cnt <= '0;
        end else if ((state == RESP) && resp_ready && (resp_err == ERR_OK)) begin
            if (we_q) begin
                store_cnt <= store_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                load_cnt  <= load_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl with a behavioural data memory.
// Expected responses are queued at issue and checked by a separate monitor.
module tb_lsu_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wr_data;
    logic        dmem_mem_wr;
    logic        dmem_mem_rd;
    logic [2:0]  dmem_mask;
    logic [31:0] dmem_rd_data;
    logic [31:0] load_cnt;
    logic [31:0] store_cnt;

    int checks;
    int failures;
    int wr_cycles;
    int rd_cycles;
    int exp_load;
    int exp_store;
    logic [33:0] exp_q[$];
    logic [31:0] mem [0:255];

    lsu_ctrl #(.DMEM_WORDS(256), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .dmem_addr(dmem_addr), .dmem_wr_data(dmem_wr_data),
        .dmem_mem_wr(dmem_mem_wr), .dmem_mem_rd(dmem_mem_rd),
        .dmem_mask(dmem_mask), .dmem_rd_data(dmem_rd_data),
        .load_cnt(load_cnt), .store_cnt(store_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // Memory model: commits on the falling edge, combinational extended read.
    always @(negedge clk) begin
        if (dmem_mem_wr) begin
            case (dmem_mask[1:0])
                2'b00:   mem[dmem_addr[9:2]][8*dmem_addr[1:0] +: 8] = dmem_wr_data[8*dmem_addr[1:0] +: 8];
                2'b01:   mem[dmem_addr[9:2]][16*dmem_addr[1] +: 16] = dmem_wr_data[16*dmem_addr[1] +: 16];
                default: mem[dmem_addr[9:2]] = dmem_wr_data;
            endcase
        end
    end

    always_comb begin
        logic [31:0] word;
        logic [7:0]  b;
        logic [15:0] h;
        word = mem[dmem_addr[9:2]];
        b = word[8*dmem_addr[1:0] +: 8];
        h = word[16*dmem_addr[1] +: 16];
        case (dmem_mask)
            3'b000:  dmem_rd_data = {{24{b[7]}}, b};
            3'b001:  dmem_rd_data = {{16{h[15]}}, h};
            3'b100:  dmem_rd_data = {24'h0, b};
            3'b101:  dmem_rd_data = {16'h0, h};
            default: dmem_rd_data = word;
        endcase
    end

    // Strobe cycle counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (dmem_mem_wr) wr_cycles++;
        if (dmem_mem_rd) rd_cycles++;
    end

    // Monitor: pop and compare whenever a response handshake is about to occur.
    always @(negedge clk) begin
        if (!rst && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                check_output("resp_unexpected", 32'd1, 32'd0);
            end else begin
                logic [33:0] e;
                e = exp_q.pop_front();
                check_output("resp_rdata", resp_rdata, e[33:2]);
                check_output("resp_err", {30'h0, resp_err}, {30'h0, e[1:0]});
            end
        end
    end

    task automatic check_reset_values(input string tag);
        check_output({tag, "_req_ready"}, {31'h0, req_ready}, 32'd1);
        check_output({tag, "_resp_valid"}, {31'h0, resp_valid}, 32'd0);
        check_output({tag, "_strobes"}, {30'h0, dmem_mem_rd, dmem_mem_wr}, 32'd0);
        check_output({tag, "_dmem_addr"}, dmem_addr, 32'd0);
        check_output({tag, "_rdata"}, resp_rdata, 32'd0);
        check_output({tag, "_err"}, {30'h0, resp_err}, 32'd0);
        check_output({tag, "_load_cnt"}, load_cnt, 32'd0);
        check_output({tag, "_store_cnt"}, store_cnt, 32'd0);
    endtask

    task automatic apply_stimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [31:0] exp_rdata,
                                  input logic [1:0] exp_err, input logic [31:0] exp_addr,
                                  input logic [31:0] exp_wdata, input int hold);
        int wr0;
        int rd0;
        int lat;
        int guard;
        logic ok;
        ok = (exp_err == 2'b00);
        exp_q.push_back({exp_rdata, exp_err});
        wr0 = wr_cycles;
        rd0 = rd_cycles;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(posedge clk); #1; guard++;
        end
        check_output("accept_ready", {31'h0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_output("dmem_addr", dmem_addr, exp_addr);
        check_output("dmem_mask", {29'h0, dmem_mask}, {29'h0, f3});
        check_output("dmem_wr_data", dmem_wr_data, exp_wdata);
        lat = 0;
        while (!resp_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        check_output("resp_latency", lat, ok ? 32'd1 : 32'd0);
        if (hold > 0) begin
            resp_ready = 1'b0;
            req_valid  = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                check_output("hold_resp_valid", {31'h0, resp_valid}, 32'd1);
                check_output("hold_req_ready", {31'h0, req_ready}, 32'd0);
                check_output("hold_rdata", resp_rdata, exp_rdata);
                check_output("hold_err", {30'h0, resp_err}, {30'h0, exp_err});
                check_output("hold_dmem_addr", dmem_addr, exp_addr);
            end
            resp_ready = 1'b1;
        end
        @(posedge clk); #1;
        check_output("idle_resp_valid", {31'h0, resp_valid}, 32'd0);
        check_output("wr_strobe_cycles", wr_cycles - wr0, (ok && we) ? 32'd1 : 32'd0);
        check_output("rd_strobe_cycles", rd_cycles - rd0, (ok && !we) ? 32'd1 : 32'd0);
        if (ok && we) exp_store++;
        if (ok && !we) exp_load++;
        check_output("load_cnt", load_cnt, exp_load);
        check_output("store_cnt", store_cnt, exp_store);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        checks = 0; failures = 0; wr_cycles = 0; rd_cycles = 0;
        exp_load = 0; exp_store = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        apply_stimulus(1'b1, 3'b010, 32'h10, 32'hA1B2C3D4, 32'h0, 2'b00, 32'h10, 32'hA1B2C3D4, 0);
        apply_stimulus(1'b0, 3'b010, 32'h10, 32'h0, 32'hA1B2C3D4, 2'b00, 32'h10, 32'h0, 0);
        apply_stimulus(1'b1, 3'b000, 32'h21, 32'h000000F5, 32'h0, 2'b00, 32'h21, 32'hF5F5F5F5, 0);
        apply_stimulus(1'b0, 3'b100, 32'h21, 32'h0, 32'h000000F5, 2'b00, 32'h21, 32'h0, 0);
        apply_stimulus(1'b0, 3'b000, 32'h21, 32'h0, 32'hFFFFFFF5, 2'b00, 32'h21, 32'h0, 0);
        apply_stimulus(1'b1, 3'b001, 32'h32, 32'h1234BEEF, 32'h0, 2'b00, 32'h32, 32'hBEEFBEEF, 0);
        apply_stimulus(1'b0, 3'b101, 32'h32, 32'h0, 32'h0000BEEF, 2'b00, 32'h32, 32'h0, 0);
        apply_stimulus(1'b0, 3'b010, 32'h30, 32'h0, 32'hBEEF0000, 2'b00, 32'h30, 32'h0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        apply_stimulus(1'b0, 3'b001, 32'h13, 32'h0, 32'h0, 2'b01, 32'h13, 32'h0, 0);
        apply_stimulus(1'b1, 3'b010, 32'h16, 32'h55555555, 32'h0, 2'b01, 32'h16, 32'h55555555, 0);
`else
        apply_stimulus(1'b0, 3'b001, 32'h13, 32'h0, 32'hFFFFA1B2, 2'b00, 32'h12, 32'h0, 0);
        apply_stimulus(1'b0, 3'b010, 32'h33, 32'h0, 32'hBEEF0000, 2'b00, 32'h30, 32'h0, 0);
`endif
        apply_stimulus(1'b0, 3'b010, 32'h400, 32'h0, 32'h0, 2'b10, 32'h400, 32'h0, 0);
        apply_stimulus(1'b1, 3'b100, 32'h40, 32'h0, 32'h0, 2'b11, 32'h40, 32'h0, 0);
        apply_stimulus(1'b0, 3'b011, 32'h13, 32'h0, 32'h0, 2'b11, 32'h13, 32'h0, 0);
        apply_stimulus(1'b0, 3'b010, 32'h10, 32'h0, 32'hA1B2C3D4, 2'b00, 32'h10, 32'h0, 5);
        apply_stimulus(1'b0, 3'b010, 32'h10, 32'h0, 32'hA1B2C3D4, 2'b00, 32'h10, 32'h0, 0);

        // Reset in the middle of a load's ACCESS cycle.
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = 32'h0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_output("access_rd_strobe", {31'h0, dmem_mem_rd}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("async_reset");
        exp_load = 0; exp_store = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        apply_stimulus(1'b0, 3'b010, 32'h10, 32'h0, 32'hA1B2C3D4, 2'b00, 32'h10, 32'h0, 0);

        check_output("queue_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
